// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter family.
// Mode encoding, direction constants and the load clamp live here.
package counter_pkg;

    typedef enum logic [1:0] {
        UP_WRAP   = 2'b00,
        DOWN_WRAP = 2'b01,
        BOUNCE    = 2'b10,
        HOLD      = 2'b11
    } cnt_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Operates on a 32-bit container so any counter width up to 32 can share it.
    function automatic logic [31:0] clamp_val(
        input logic [31:0] val,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [31:0] res;
        res = val;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_counter_gen.sv
// Up/down counter with wrap, bounce and hold modes, enable, clamped load
// and a registered one-cycle terminal-count pulse.
module updown_counter_gen
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  cnt_mode_t        mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cont,
    output logic             dir,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_VAL);

    if (WIDTH < 1 || WIDTH > 32 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
        longint'(MAX_VAL) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_param_check
        $error("updown_counter_gen: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1, WIDTH 1..32");
    end

    logic [WIDTH-1:0] r_cont;
    logic             r_dir;
    logic             r_tc;

    logic [WIDTH-1:0] w_cont_nxt;
    logic             w_dir_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_clamped = WIDTH'(clamp_val(32'(load_val), 32'(MIN_VAL), 32'(MAX_VAL)));

    // Bounds are tested before stepping, so the +1/-1 can never overflow.
    always_comb begin
        w_cont_nxt = r_cont;
        w_dir_nxt  = r_dir;
        w_tc_nxt   = 1'b0;
        if (load) begin
            w_cont_nxt = w_load_clamped;
        end else if (en) begin
            case (mode)
                UP_WRAP: begin
                    w_dir_nxt = DIR_UP;
                    if (r_cont == HI) begin
                        w_cont_nxt = LO;
                        w_tc_nxt   = 1'b1;
                    end else begin
                        w_cont_nxt = r_cont + 1'b1;
                        w_tc_nxt   = (w_cont_nxt == HI);
                    end
                end
                DOWN_WRAP: begin
                    w_dir_nxt = DIR_DOWN;
                    if (r_cont == LO) begin
                        w_cont_nxt = HI;
                        w_tc_nxt   = 1'b1;
                    end else begin
                        w_cont_nxt = r_cont - 1'b1;
                        w_tc_nxt   = (w_cont_nxt == LO);
                    end
                end
                BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        if (r_cont == HI) begin
                            w_dir_nxt  = DIR_DOWN;
                            w_cont_nxt = HI - 1'b1;
                            w_tc_nxt   = (w_cont_nxt == LO);
                        end else begin
                            w_cont_nxt = r_cont + 1'b1;
                            w_tc_nxt   = (w_cont_nxt == HI);
                        end
                    end else begin
                        if (r_cont == LO) begin
                            w_dir_nxt  = DIR_UP;
                            w_cont_nxt = LO + 1'b1;
                            w_tc_nxt   = (w_cont_nxt == HI);
                        end else begin
                            w_cont_nxt = r_cont - 1'b1;
                            w_tc_nxt   = (w_cont_nxt == LO);
                        end
                    end
                end
                default: begin
                    w_cont_nxt = r_cont;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cont <= LO;
            r_dir  <= DIR_UP;
            r_tc   <= 1'b0;
        end else begin
            r_cont <= w_cont_nxt;
            r_dir  <= w_dir_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign cont = r_cont;
    assign dir  = r_dir;
    assign tc   = r_tc;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed vector bench for updown_counter_gen: default 0..15 instance
// and a 3..9 instance, each vector checked one cycle after it is applied.
module tb_updown_counter_gen;
    import counter_pkg::*;

    typedef struct {
        bit        sel;
        logic      rst;
        logic      en;
        cnt_mode_t mode;
        logic      ld;
        logic [3:0] lv;
        logic [3:0] ec;
        logic      ed;
        logic      et;
        string     tag;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, en0 = 1'b0, ld0 = 1'b0;
    cnt_mode_t  mode0 = HOLD;
    logic [3:0] lv0 = '0;
    logic [3:0] cont0;
    logic       dir0, tc0;

    logic       rst1 = 1'b0, en1 = 1'b0, ld1 = 1'b0;
    cnt_mode_t  mode1 = HOLD;
    logic [3:0] lv1 = '0;
    logic [3:0] cont1;
    logic       dir1, tc1;

    updown_counter_gen #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15)) dut0 (
        .clk(clk), .reset(rst0), .en(en0), .mode(mode0), .load(ld0),
        .load_val(lv0), .cont(cont0), .dir(dir0), .tc(tc0)
    );

    updown_counter_gen #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9)) dut1 (
        .clk(clk), .reset(rst1), .en(en1), .mode(mode1), .load(ld1),
        .load_val(lv1), .cont(cont1), .dir(dir1), .tc(tc1)
    );

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(bit sel, logic rst, logic en, cnt_mode_t mode, logic ld,
                                int lv, int ec, logic ed, logic et, string tag);
        vec_t v;
        v.sel = sel; v.rst = rst; v.en = en; v.mode = mode; v.ld = ld;
        v.lv = 4'(lv); v.ec = 4'(ec); v.ed = ed; v.et = et; v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [5:0] got, exp;
        rst0 = 1'b0; en0 = 1'b0; ld0 = 1'b0;
        rst1 = 1'b0; en1 = 1'b0; ld1 = 1'b0;
        if (!v.sel) begin
            rst0 = v.rst; en0 = v.en; mode0 = v.mode; ld0 = v.ld; lv0 = v.lv;
        end else begin
            rst1 = v.rst; en1 = v.en; mode1 = v.mode; ld1 = v.ld; lv1 = v.lv;
        end
        @(posedge clk);
        #1;
        got = v.sel ? {cont1, dir1, tc1} : {cont0, dir0, tc0};
        exp = {v.ec, v.ed, v.et};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got cont=%0d dir=%0b tc=%0b, expected cont=%0d dir=%0b tc=%0b",
                     idx, v.tag, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // ---- dut0 (0..15): reset, then a full bounce sweep
        add(0, 1, 0, UP_WRAP, 0, 0, 0, 0, 0, "reset0");
        for (int k = 1; k <= 15; k++) add(0, 0, 1, BOUNCE, 0, 0, k, 0, (k == 15), "bounce_up");
        for (int k = 14; k >= 0; k--) add(0, 0, 1, BOUNCE, 0, 0, k, 1, (k == 0), "bounce_dn");
        add(0, 0, 1, BOUNCE, 0, 0, 1, 0, 0, "bounce_turn");

        // UP_WRAP from reset
        add(0, 1, 1, UP_WRAP, 0, 0, 0, 0, 0, "reset_up");
        for (int k = 1; k <= 15; k++) add(0, 0, 1, UP_WRAP, 0, 0, k, 0, (k == 15), "upwrap");
        add(0, 0, 1, UP_WRAP, 0, 0, 0, 0, 1, "upwrap_wrap");
        add(0, 0, 1, UP_WRAP, 0, 0, 1, 0, 0, "upwrap_after");

        // DOWN_WRAP from 2
        add(0, 0, 0, DOWN_WRAP, 1, 2, 2, 0, 0, "load2");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 1, 1, 0, "dnwrap");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 0, 1, 1, "dnwrap_min");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 15, 1, 1, "dnwrap_wrap");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 14, 1, 0, "dnwrap_after");

        // enable low, then HOLD mode, at 7
        add(0, 0, 0, UP_WRAP, 1, 7, 7, 1, 0, "load7");
        for (int k = 0; k < 3; k++) add(0, 0, 0, UP_WRAP, 0, 0, 7, 1, 0, "en_low");
        for (int k = 0; k < 3; k++) add(0, 0, 1, HOLD, 0, 0, 7, 1, 0, "hold_mode");
        add(0, 0, 1, UP_WRAP, 0, 0, 8, 0, 0, "resume_up");

        // reset mid-sweep while bouncing down at 5
        add(0, 0, 0, DOWN_WRAP, 1, 7, 7, 0, 0, "load7b");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 6, 1, 0, "dn_to6");
        add(0, 0, 1, BOUNCE, 0, 0, 5, 1, 0, "bounce_to5");
        add(0, 1, 1, BOUNCE, 0, 0, 0, 0, 0, "reset_mid");
        add(0, 0, 1, BOUNCE, 0, 0, 1, 0, 0, "after_reset");

        // mode changes mid-count
        add(0, 0, 0, UP_WRAP, 1, 5, 5, 0, 0, "load5");
        add(0, 0, 1, UP_WRAP, 0, 0, 6, 0, 0, "up_to6");
        for (int k = 7; k <= 15; k++) add(0, 0, 1, BOUNCE, 0, 0, k, 0, (k == 15), "sw_bounce");
        add(0, 0, 1, BOUNCE, 0, 0, 14, 1, 0, "sw_bounce_turn");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 13, 1, 0, "sw_dnwrap");
        add(0, 0, 1, DOWN_WRAP, 0, 0, 12, 1, 0, "sw_dnwrap2");
        add(0, 0, 1, BOUNCE, 0, 0, 11, 1, 0, "bounce_keeps_dir");
        add(0, 0, 0, DOWN_WRAP, 1, 15, 15, 1, 0, "load_max");
        add(0, 0, 1, BOUNCE, 0, 0, 14, 1, 0, "bounce_dn_from_max");

        // ---- dut1 (3..9)
        add(1, 1, 0, UP_WRAP, 0, 0, 3, 0, 0, "reset1");
        for (int k = 4; k <= 9; k++) add(1, 0, 1, BOUNCE, 0, 0, k, 0, (k == 9), "b1_up");
        for (int k = 8; k >= 3; k--) add(1, 0, 1, BOUNCE, 0, 0, k, 1, (k == 3), "b1_dn");
        add(1, 0, 1, BOUNCE, 0, 0, 4, 0, 0, "b1_turn");
        add(1, 0, 0, BOUNCE, 1, 12, 9, 0, 0, "clamp_hi");
        add(1, 0, 0, BOUNCE, 1, 1, 3, 0, 0, "clamp_lo");
        add(1, 0, 1, BOUNCE, 1, 8, 8, 0, 0, "load_beats_en");
        add(1, 0, 1, UP_WRAP, 0, 0, 9, 0, 1, "up1_max");
        add(1, 0, 1, UP_WRAP, 1, 9, 9, 0, 0, "load_no_tc");
        add(1, 0, 1, UP_WRAP, 0, 0, 3, 0, 1, "up1_wrap");
        add(1, 0, 1, DOWN_WRAP, 0, 0, 9, 1, 1, "dn1_wrap");
        add(1, 0, 1, DOWN_WRAP, 1, 15, 9, 1, 0, "clamp_hi_dir_kept");
        add(1, 0, 1, DOWN_WRAP, 0, 0, 8, 1, 0, "dn1_step");

        foreach (vecs[i]) apply(vecs[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
- Parametrised up/down counter with a selectable counting mode, enable, synchronous load and a terminal-count pulse.
- Next generation of the 4-bit 0..15 bouncing counter, generalised in width, range and mode.
- Used as a sweep or address generator and a general timing counter inside the exercise designs.
- Single clock domain, fully registered outputs.

Parameters:
- WIDTH, 4, counter width in bits.
- MIN_VAL, 0, lower bound of the count range (inclusive).
- MAX_VAL, 15, upper bound of the count range (inclusive); must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; when 0, the count holds.
- mode  in  2  counting mode: 00 UP_WRAP, 01 DOWN_WRAP, 10 BOUNCE, 11 HOLD.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- cont  out  WIDTH  current count.
- dir  out  1  current direction: 0 = up, 1 = down.
- tc  out  1  terminal-count pulse, one cycle wide.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Priority per edge: reset > load > (en and mode != HOLD) > hold.
- Reset values: cont = MIN_VAL, dir = 0, tc = 0. Reset asserted mid-sweep takes effect on the next edge with no residual state.
- Load:
  - cont <= load_val, clamped: values below MIN_VAL load MIN_VAL, values above MAX_VAL load MAX_VAL.
  - dir is unchanged and tc <= 0.
  - Load wins over en in the same cycle.
- Counting (en=1), step 1, latency 1 cycle:
  - UP_WRAP: dir <= 0. cont == MAX_VAL -> cont <= MIN_VAL; otherwise cont + 1.
  - DOWN_WRAP: dir <= 1. cont == MIN_VAL -> cont <= MAX_VAL; otherwise cont - 1.
  - BOUNCE, dir=0: cont == MAX_VAL -> dir <= 1, cont <= MAX_VAL-1; otherwise cont + 1.
  - BOUNCE, dir=1: cont == MIN_VAL -> dir <= 0, cont <= MIN_VAL+1; otherwise cont - 1.
  - Each bound therefore appears for exactly one cycle per bounce; there is no dwell at the bound.
  - HOLD: cont and dir unchanged, tc <= 0.
- en=0: cont and dir hold, tc <= 0.
- tc:
  - tc <= 1 on the edge where counting moves cont onto the bound in the direction of travel: onto MAX_VAL while counting up, onto MIN_VAL while counting down.
  - Wrap transitions count: MAX_VAL->MIN_VAL in UP_WRAP and MIN_VAL->MAX_VAL in DOWN_WRAP both set tc.
  - tc is 0 on every other edge, including load, hold and reset.
- Mode change mid-count: takes effect on the same edge. BOUNCE continues with the current dir value (which a prior wrap mode may have forced).
- Width rules:
  - All arithmetic is WIDTH bits.
  - cont never leaves [MIN_VAL, MAX_VAL] after reset.
  - No overflow is possible, because bounds are checked before the +1 or -1.
- Every register update uses non-blocking assignment only.
- Elaboration check: the parameter constraints are enforced with $error.

Decomposition:
- Shared package counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {UP_WRAP, DOWN_WRAP, BOUNCE, HOLD};
  - localparam DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- No sub-module. The block is a single always_ff plus a next-state always_comb; the clamp logic lives in a package function clamp_val.

Test Plan:
- Defaults (0..15), BOUNCE: reset then en=1 for 32 cycles -> cont 0,1..15,14..0,1. dir goes 1 after cont=15 and 0 after cont=0. tc high in the cycles cont=15 and cont=0 (reached by counting).
- UP_WRAP with en=1 from reset -> 0..15,0,1. tc=1 when cont=15 and again when it wraps to 0. DOWN_WRAP from cont=2 -> 2,1,0,15,14 with tc at 0 and at 15.
- MIN_VAL=3, MAX_VAL=9, BOUNCE -> reset gives cont=3, then 4..9,8..3,4. load_val=12 -> cont=9. load_val=1 -> cont=3. load together with en -> load value wins, tc=0.
- en toggled low at cont=7 for 3 cycles -> cont stays 7, tc=0. mode=HOLD -> same result.
- BOUNCE counting down at cont=5, reset pulsed 1 cycle -> next cont=0, dir=0, tc=0. Counting resumes at 1.
- UP_WRAP at cont=6, switch to BOUNCE with dir=0 -> continues 7..15,14. Switch to DOWN_WRAP at cont=14 -> 13,12 with dir=1.
